// File: rtl/multicycle_control_fsm.sv
// Multicycle MIPS main control unit.
// Sequences fetch, decode, execute, memory and writeback. It drives the
// datapath mux selects, the write enables and the ALUOp code consumed by the
// ALU control decoder. Outputs decode combinationally from the registered state.
// Memory states (FETCH, MEM_RD, MEM_WR) count the cycles spent waiting on
// mem_ready. If the wait reaches TIMEOUT_CYCLES, the FSM traps to ILLEGAL.
// Optional build macro: BRANCH_EN adds BEQ support (BRANCH state, zero input).
//
// state     | code | meaning
// ----------+------+-------------------------------------------------------
// FETCH     |  0   | read instruction at PC, PC+4; load IR/PC on mem_ready
// DECODE    |  1   | compute branch target into ALUOut, dispatch on opcode
// R_EXEC    |  2   | rs op rt, function field selects the ALU operation
// R_WB      |  3   | write ALUOut to rd
// I_EXEC    |  4   | rs op sign-ext imm (ADDI / ORI / ANDI)
// I_WB      |  5   | write ALUOut to rt
// MEM_ADDR  |  6   | rs + sign-ext imm -> effective address
// MEM_RD    |  7   | load data read, wait on mem_ready
// MEM_WB    |  8   | write MDR to rt
// MEM_WR    |  9   | store data write, wait on mem_ready
// JUMP      | 10   | load PC with jump target
// BRANCH    | 11   | BEQ compare, load PC from ALUOut when zero (BRANCH_EN)
// ILLEGAL   | 15   | trap, all strobes off until reset
module multicycle_control_fsm #(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int TIMEOUT_W      = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic       mem_ready,
`ifdef BRANCH_EN
   input  logic       zero,
`endif
   output logic       PCWrite,
   output logic       IRWrite,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IorD,
   output logic       RegWrite,
   output logic       RegDst,
   output logic       MemtoReg,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] PCSource,
   output logic [2:0] ALUOp,
   output logic       illegal_op,
   output logic       mem_timeout,
   output logic [3:0] state_o
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_R_EXEC   = 4'd2,
      S_R_WB     = 4'd3,
      S_I_EXEC   = 4'd4,
      S_I_WB     = 4'd5,
      S_MEM_ADDR = 4'd6,
      S_MEM_RD   = 4'd7,
      S_MEM_WB   = 4'd8,
      S_MEM_WR   = 4'd9,
      S_JUMP     = 4'd10,
      S_BRANCH   = 4'd11,
      S_ILLEGAL  = 4'd15
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_J     = 6'b000010;
`ifdef BRANCH_EN
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [2:0] ALU_SUB  = 3'b011;
`endif

   localparam logic [2:0] ALU_IDLE  = 3'b000;
   localparam logic [2:0] ALU_AND   = 3'b001;
   localparam logic [2:0] ALU_OR    = 3'b101;
   localparam logic [2:0] ALU_ADD   = 3'b110;
   localparam logic [2:0] ALU_RTYPE = 3'b111;

   // Count value on the last permitted wait cycle; a miss here expires.
   localparam logic [TIMEOUT_W-1:0] WAIT_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

   state_t               state;
   state_t               state_nxt;
   logic [TIMEOUT_W-1:0] wait_cnt;
   logic [TIMEOUT_W-1:0] wait_cnt_nxt;
   logic                 in_wait;
   logic                 wait_hit;
   logic                 wait_expired;
   logic                 illegal_set;

   // State register, wait counter and sticky trap flags.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state       <= S_FETCH;
         wait_cnt    <= '0;
         illegal_op  <= 1'b0;
         mem_timeout <= 1'b0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
         if (illegal_set) begin
            illegal_op <= 1'b1;
         end
         if (wait_expired) begin
            mem_timeout <= 1'b1;
         end
      end
   end

   // Next-state selection and wait-counter update.
   always_comb begin
      state_nxt    = state;
      wait_expired = 1'b0;
      in_wait      = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
      // mem_ready is checked before wait_hit, so a response on the last cycle wins.
      wait_hit     = (wait_cnt == WAIT_LAST) && !mem_ready;

      case (state)
         S_FETCH: begin
            if (mem_ready) begin
               state_nxt = S_DECODE;
            end else if (wait_hit) begin
               state_nxt    = S_ILLEGAL;
               wait_expired = 1'b1;
            end
         end
         S_DECODE: begin
            case (opcode)
               OP_RTYPE:                 state_nxt = S_R_EXEC;
               OP_ADDI, OP_ORI, OP_ANDI: state_nxt = S_I_EXEC;
               OP_LW, OP_SW:             state_nxt = S_MEM_ADDR;
               OP_J:                     state_nxt = S_JUMP;
`ifdef BRANCH_EN
               OP_BEQ:                   state_nxt = S_BRANCH;
`endif
               default:                  state_nxt = S_ILLEGAL;
            endcase
         end
         S_R_EXEC:   state_nxt = S_R_WB;
         S_R_WB:     state_nxt = S_FETCH;
         S_I_EXEC:   state_nxt = S_I_WB;
         S_I_WB:     state_nxt = S_FETCH;
         // IR holds the opcode, so only LW/SW can reach MEM_ADDR.
         S_MEM_ADDR: state_nxt = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
         S_MEM_RD: begin
            if (mem_ready) begin
               state_nxt = S_MEM_WB;
            end else if (wait_hit) begin
               state_nxt    = S_ILLEGAL;
               wait_expired = 1'b1;
            end
         end
         S_MEM_WB:   state_nxt = S_FETCH;
         S_MEM_WR: begin
            if (mem_ready) begin
               state_nxt = S_FETCH;
            end else if (wait_hit) begin
               state_nxt    = S_ILLEGAL;
               wait_expired = 1'b1;
            end
         end
         S_JUMP:     state_nxt = S_FETCH;
`ifdef BRANCH_EN
         S_BRANCH:   state_nxt = S_FETCH;
`endif
         S_ILLEGAL:  state_nxt = S_ILLEGAL;
         default:    state_nxt = S_ILLEGAL;
      endcase

      illegal_set = (state == S_DECODE) && (state_nxt == S_ILLEGAL);

      wait_cnt_nxt = wait_cnt;
      if (state_nxt != state) begin
         wait_cnt_nxt = '0;
      end else if (in_wait && !mem_ready) begin
         wait_cnt_nxt = wait_cnt + TIMEOUT_W'(1);
      end
   end

   // Datapath controls decoded from the current state; held off during reset.
   always_comb begin
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      IorD     = 1'b0;
      RegWrite = 1'b0;
      RegDst   = 1'b0;
      MemtoReg = 1'b0;
      ALUSrcA  = 1'b0;
      ALUSrcB  = 2'b00;
      PCSource = 2'b00;
      ALUOp    = ALU_IDLE;

      if (reset) begin
         case (state)
            S_FETCH: begin
               MemRead = 1'b1;
               IRWrite = mem_ready;
               PCWrite = mem_ready;
               ALUSrcB = 2'b01;
               ALUOp   = ALU_ADD;
            end
            S_DECODE: begin
               ALUSrcB = 2'b11;
               ALUOp   = ALU_ADD;
            end
            S_R_EXEC: begin
               ALUSrcA = 1'b1;
               ALUOp   = ALU_RTYPE;
            end
            S_R_WB: begin
               RegWrite = 1'b1;
               RegDst   = 1'b1;
            end
            S_I_EXEC: begin
               ALUSrcA = 1'b1;
               ALUSrcB = 2'b10;
               case (opcode)
                  OP_ADDI: ALUOp = ALU_ADD;
                  OP_ORI:  ALUOp = ALU_OR;
                  OP_ANDI: ALUOp = ALU_AND;
                  default: ALUOp = ALU_IDLE;
               endcase
            end
            S_I_WB: begin
               RegWrite = 1'b1;
            end
            S_MEM_ADDR: begin
               ALUSrcA = 1'b1;
               ALUSrcB = 2'b10;
               ALUOp   = ALU_ADD;
            end
            S_MEM_RD: begin
               MemRead = 1'b1;
               IorD    = 1'b1;
            end
            S_MEM_WB: begin
               RegWrite = 1'b1;
               MemtoReg = 1'b1;
            end
            S_MEM_WR: begin
               MemWrite = 1'b1;
               IorD     = 1'b1;
            end
            S_JUMP: begin
               PCWrite  = 1'b1;
               PCSource = 2'b10;
            end
`ifdef BRANCH_EN
            S_BRANCH: begin
               ALUSrcA  = 1'b1;
               ALUOp    = ALU_SUB;
               PCSource = 2'b01;
               PCWrite  = zero;
            end
`endif
            default: ;
         endcase
      end
   end

   assign state_o = state;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: directed vector table, hand sequences for
// trap/timeout corners, then random stimulus against an instruction-level model.
module tb_multicycle_control_fsm;

   localparam int TO = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] opcode;
   logic       mem_ready;
`ifdef BRANCH_EN
   logic       zero;
`endif
   logic       PCWrite, IRWrite, MemRead, MemWrite, IorD, RegWrite, RegDst, MemtoReg, ALUSrcA;
   logic [1:0] ALUSrcB, PCSource;
   logic [2:0] ALUOp;
   logic       illegal_op, mem_timeout;
   logic [3:0] state_o;

   always #5 clk = ~clk;

   multicycle_control_fsm #(.TIMEOUT_CYCLES(TO), .TIMEOUT_W(8)) dut (
      .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
`ifdef BRANCH_EN
      .zero(zero),
`endif
      .PCWrite(PCWrite), .IRWrite(IRWrite), .MemRead(MemRead), .MemWrite(MemWrite),
      .IorD(IorD), .RegWrite(RegWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource), .ALUOp(ALUOp),
      .illegal_op(illegal_op), .mem_timeout(mem_timeout), .state_o(state_o)
   );

   // strb bits: [8]PCWrite [7]IRWrite [6]MemRead [5]MemWrite [4]IorD
   //            [3]RegWrite [2]RegDst [1]MemtoReg [0]ALUSrcA
   typedef struct packed {
      logic [8:0] strb;
      logic [1:0] srcb;
      logic [1:0] pcsrc;
      logic [2:0] aluop;
      logic [3:0] st;
      logic       ill;
      logic       tmo;
   } obs_t;

   typedef struct {
      logic       rst;
      logic [5:0] op;
      logic       mr;
      obs_t       exp;
   } vec_t;

   obs_t act;
   assign act = {PCWrite, IRWrite, MemRead, MemWrite, IorD, RegWrite, RegDst, MemtoReg,
                 ALUSrcA, ALUSrcB, PCSource, ALUOp, state_o, illegal_op, mem_timeout};

   int checks = 0;
   int errors = 0;

   localparam logic [5:0] R = 6'b000000, ADDI = 6'b001000, ORI = 6'b001101, ANDI = 6'b001100;
   localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, J = 6'b000010, BEQ = 6'b000100;

   // Mux selects are not specified while reset is held, so they are masked then.
   task automatic check(string name, obs_t exp, bit care_mux);
      obs_t a;
      a = act;
      if (!care_mux) begin
         a.srcb = '0; a.pcsrc = '0; exp.srcb = '0; exp.pcsrc = '0;
      end
      checks++;
      if (a !== exp) begin
         errors++;
         $display("FAIL %s t=%0t: got strb=%b srcb=%b pcsrc=%b aluop=%b st=%0d ill=%b tmo=%b, want strb=%b srcb=%b pcsrc=%b aluop=%b st=%0d ill=%b tmo=%b",
                  name, $time, a.strb, a.srcb, a.pcsrc, a.aluop, a.st, a.ill, a.tmo,
                  exp.strb, exp.srcb, exp.pcsrc, exp.aluop, exp.st, exp.ill, exp.tmo);
      end
   endtask

   function automatic obs_t ob(logic [8:0] sb, logic [1:0] b, logic [1:0] p, logic [2:0] a,
                               logic [3:0] s, logic il, logic tm);
      obs_t o;
      o.strb = sb; o.srcb = b; o.pcsrc = p; o.aluop = a; o.st = s; o.ill = il; o.tmo = tm;
      return o;
   endfunction

   function automatic vec_t v(logic r, logic [5:0] o, logic m, logic [8:0] sb, logic [1:0] b,
                              logic [1:0] p, logic [2:0] a, logic [3:0] s);
      vec_t t;
      t.rst = r; t.op = o; t.mr = m;
      t.exp = ob(sb, b, p, a, s, 1'b0, 1'b0);
      return t;
   endfunction

   // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
   task automatic drive(logic r, logic [5:0] o, logic m);
      reset = r; opcode = o; mem_ready = m;
      #4;
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   // ---------------- reference model (instruction level) ----------------
   int   m_state;
   int   m_q[$];
   int   m_wait;
   logic m_ill, m_tmo;

   task automatic model_step(logic r, logic [5:0] o, logic m);
      if (!r) begin
         m_state = 0; m_q.delete(); m_wait = 0; m_ill = 0; m_tmo = 0;
         return;
      end
      if (m_state == 15) return;
      if (m_state == 0 || m_state == 7 || m_state == 9) begin
         if (m) begin
            m_wait = 0;
            if (m_state == 0) begin
               m_q.delete();
               m_q.push_back(1);
               case (o)
                  R:               begin m_q.push_back(2); m_q.push_back(3); end
                  ADDI, ORI, ANDI: begin m_q.push_back(4); m_q.push_back(5); end
                  LW:              begin m_q.push_back(6); m_q.push_back(7); m_q.push_back(8); end
                  SW:              begin m_q.push_back(6); m_q.push_back(9); end
                  J:               m_q.push_back(10);
`ifdef BRANCH_EN
                  BEQ:             m_q.push_back(11);
`endif
                  default:         m_q.push_back(15);
               endcase
            end
            if (m_q.size() > 0) m_state = m_q.pop_front();
            else                m_state = 0;
         end else begin
            m_wait++;
            if (m_wait == TO) begin
               m_tmo = 1; m_state = 15; m_wait = 0; m_q.delete();
            end
         end
      end else begin
         if (m_state == 1 && m_q.size() > 0 && m_q[0] == 15) m_ill = 1;
         if (m_q.size() > 0) m_state = m_q.pop_front();
         else                m_state = 0;
      end
   endtask

   function automatic obs_t model_out(logic r, logic [5:0] o, logic m);
      obs_t e;
      e = '0;
      e.st = 4'(m_state); e.ill = m_ill; e.tmo = m_tmo;
      if (r) begin
         case (m_state)
            0:  begin e.strb[6] = 1; e.strb[8] = m; e.strb[7] = m; e.srcb = 2'b01; e.aluop = 3'b110; end
            1:  begin e.srcb = 2'b11; e.aluop = 3'b110; end
            2:  begin e.strb[0] = 1; e.aluop = 3'b111; end
            3:  begin e.strb[3] = 1; e.strb[2] = 1; end
            4:  begin
                   e.strb[0] = 1; e.srcb = 2'b10;
                   e.aluop = (o == ADDI) ? 3'b110 : (o == ORI) ? 3'b101 : (o == ANDI) ? 3'b001 : 3'b000;
                end
            5:  e.strb[3] = 1;
            6:  begin e.strb[0] = 1; e.srcb = 2'b10; e.aluop = 3'b110; end
            7:  begin e.strb[6] = 1; e.strb[4] = 1; end
            8:  begin e.strb[3] = 1; e.strb[1] = 1; end
            9:  begin e.strb[5] = 1; e.strb[4] = 1; end
            10: begin e.strb[8] = 1; e.pcsrc = 2'b10; end
`ifdef BRANCH_EN
            11: begin e.strb[0] = 1; e.strb[8] = zero; e.aluop = 3'b011; e.pcsrc = 2'b01; end
`endif
            default: ;
         endcase
      end
      return e;
   endfunction

   localparam logic [8:0] S_FW = 9'b001000000, S_FF = 9'b111000000, S_EX = 9'b000000001;

   vec_t tbl[$];

   initial begin
      logic [5:0] cur_op;
      logic       r, m;
      logic [5:0] pool [8];
      pool = '{R, ADDI, ORI, ANDI, LW, SW, J, BEQ};

      // Directed table: reset, R-type, I-types, LW with memory stall, SW, J.
      tbl.push_back(v(0, R, 1, 9'b0, 2'b00, 2'b00, 3'b000, 0));
      tbl.push_back(v(1, R, 0, S_FW, 2'b01, 2'b00, 3'b110, 0));
      tbl.push_back(v(1, R, 1, S_FF, 2'b01, 2'b00, 3'b110, 0));
      tbl.push_back(v(1, R, 0, 9'b0, 2'b11, 2'b00, 3'b110, 1));
      tbl.push_back(v(1, R, 0, S_EX, 2'b00, 2'b00, 3'b111, 2));
      tbl.push_back(v(1, R, 0, 9'b000001100, 2'b00, 2'b00, 3'b000, 3));
      tbl.push_back(v(1, ADDI, 1, S_FF, 2'b01, 2'b00, 3'b110, 0));
      tbl.push_back(v(1, ADDI, 0, 9'b0, 2'b11, 2'b00, 3'b110, 1));
      tbl.push_back(v(1, ADDI, 0, S_EX, 2'b10, 2'b00, 3'b110, 4));
      tbl.push_back(v(1, ADDI, 0, 9'b000001000, 2'b00, 2'b00, 3'b000, 5));
      tbl.push_back(v(1, ORI, 1, S_FF, 2'b01, 2'b00, 3'b110, 0));
      tbl.push_back(v(1, ORI, 0, 9'b0, 2'b11, 2'b00, 3'b110, 1));
      tbl.push_back(v(1, ORI, 0, S_EX, 2'b10, 2'b00, 3'b101, 4));
      tbl.push_back(v(1, ORI, 0, 9'b000001000, 2'b00, 2'b00, 3'b000, 5));
      tbl.push_back(v(1, ANDI, 1, S_FF, 2'b01, 2'b00, 3'b110, 0));
      tbl.push_back(v(1, ANDI, 0, 9'b0, 2'b11, 2'b00, 3'b110, 1));
      tbl.push_back(v(1, ANDI, 0, S_EX, 2'b10, 2'b00, 3'b001, 4));
      tbl.push_back(v(1, ANDI, 0, 9'b000001000, 2'b00, 2'b00, 3'b000, 5));
      tbl.push_back(v(1, LW, 1, S_FF, 2'b01, 2'b00, 3'b110, 0));
      tbl.push_back(v(1, LW, 0, 9'b0, 2'b11, 2'b00, 3'b110, 1));
      tbl.push_back(v(1, LW, 0, S_EX, 2'b10, 2'b00, 3'b110, 6));
      tbl.push_back(v(1, LW, 0, 9'b001010000, 2'b00, 2'b00, 3'b000, 7));
      tbl.push_back(v(1, LW, 0, 9'b001010000, 2'b00, 2'b00, 3'b000, 7));
      tbl.push_back(v(1, LW, 0, 9'b001010000, 2'b00, 2'b00, 3'b000, 7));
      tbl.push_back(v(1, LW, 1, 9'b001010000, 2'b00, 2'b00, 3'b000, 7));
      tbl.push_back(v(1, LW, 0, 9'b000001010, 2'b00, 2'b00, 3'b000, 8));
      tbl.push_back(v(1, LW, 0, S_FW, 2'b01, 2'b00, 3'b110, 0));
      tbl.push_back(v(1, SW, 1, S_FF, 2'b01, 2'b00, 3'b110, 0));
      tbl.push_back(v(1, SW, 0, 9'b0, 2'b11, 2'b00, 3'b110, 1));
      tbl.push_back(v(1, SW, 0, S_EX, 2'b10, 2'b00, 3'b110, 6));
      tbl.push_back(v(1, SW, 1, 9'b000110000, 2'b00, 2'b00, 3'b000, 9));
      tbl.push_back(v(1, J, 1, S_FF, 2'b01, 2'b00, 3'b110, 0));
      tbl.push_back(v(1, J, 0, 9'b0, 2'b11, 2'b00, 3'b110, 1));
      tbl.push_back(v(1, J, 0, 9'b100000000, 2'b00, 2'b10, 3'b000, 10));
      tbl.push_back(v(1, J, 0, S_FW, 2'b01, 2'b00, 3'b110, 0));

`ifdef BRANCH_EN
      zero = 1'b0;
`endif
      reset = 1'b0; opcode = '0; mem_ready = 1'b0;
      @(posedge clk);
      adv();

      foreach (tbl[i]) begin
         drive(tbl[i].rst, tbl[i].op, tbl[i].mr);
         check($sformatf("vec%0d", i), tbl[i].exp, tbl[i].rst);
         adv();
      end

      // Illegal opcode: trap is sticky for 20 cycles, cleared by one reset edge.
      drive(1, 6'b111111, 1); check("ill_fetch", ob(S_FF, 2'b01, 2'b00, 3'b110, 0, 0, 0), 1); adv();
      drive(1, 6'b111111, 0); check("ill_decode", ob(9'b0, 2'b11, 2'b00, 3'b110, 1, 0, 0), 1); adv();
      for (int k = 0; k < 20; k++) begin
         drive(1, 6'b111111, 1'($urandom_range(0, 1)));
         check($sformatf("ill_hold%0d", k), ob(9'b0, 2'b00, 2'b00, 3'b000, 15, 1, 0), 1);
         adv();
      end
      drive(0, 6'b111111, 1); check("ill_rst", ob(9'b0, 2'b00, 2'b00, 3'b000, 15, 1, 0), 0); adv();
      drive(1, R, 0); check("ill_cleared", ob(S_FW, 2'b01, 2'b00, 3'b110, 0, 0, 0), 1); adv();

      // BEQ opcode: traps without the branch option, branches with it.
      drive(1, BEQ, 1); check("beq_fetch", ob(S_FF, 2'b01, 2'b00, 3'b110, 0, 0, 0), 1); adv();
      drive(1, BEQ, 0); check("beq_decode", ob(9'b0, 2'b11, 2'b00, 3'b110, 1, 0, 0), 1); adv();
`ifdef BRANCH_EN
      zero = 1'b1;
      drive(1, BEQ, 0); check("beq_branch", ob(9'b100000001, 2'b00, 2'b01, 3'b011, 11, 0, 0), 1); adv();
      drive(1, BEQ, 0); check("beq_back", ob(S_FW, 2'b01, 2'b00, 3'b110, 0, 0, 0), 1); adv();
`else
      drive(1, BEQ, 0); check("beq_trap", ob(9'b0, 2'b00, 2'b00, 3'b000, 15, 1, 0), 1); adv();
`endif
      drive(0, R, 0); adv();

      // Fetch timeout: four stalled cycles trap; a response on the fourth wins.
      for (int k = 0; k < TO; k++) begin
         drive(1, R, 0); check($sformatf("to_wait%0d", k), ob(S_FW, 2'b01, 2'b00, 3'b110, 0, 0, 0), 1); adv();
      end
      drive(1, R, 0); check("to_trap", ob(9'b0, 2'b00, 2'b00, 3'b000, 15, 0, 1), 1); adv();
      drive(0, R, 0); adv();
      for (int k = 0; k < TO - 1; k++) begin
         drive(1, R, 0); check($sformatf("nto_wait%0d", k), ob(S_FW, 2'b01, 2'b00, 3'b110, 0, 0, 0), 1); adv();
      end
      drive(1, R, 1); check("nto_last", ob(S_FF, 2'b01, 2'b00, 3'b110, 0, 0, 0), 1); adv();
      drive(1, R, 0); check("nto_decode", ob(9'b0, 2'b11, 2'b00, 3'b110, 1, 0, 0), 1); adv();

      // Random phase against the instruction-level model.
      drive(0, R, 0); adv(); model_step(0, R, 0);
      cur_op = R;
      for (int n = 0; n < 3000; n++) begin
         if (m_state == 15) r = ($urandom_range(0, 3) != 0);
         else               r = ($urandom_range(0, 59) != 0);
         if (m_state == 0) begin
            if ($urandom_range(0, 7) == 0) cur_op = 6'($urandom_range(0, 63));
            else                           cur_op = pool[$urandom_range(0, 7)];
         end
         m = ($urandom_range(0, 99) < 55);
`ifdef BRANCH_EN
         zero = 1'($urandom_range(0, 1));
`endif
         drive(r, cur_op, m);
         check("rand", model_out(r, cur_op, m), r);
         adv();
         model_step(r, cur_op, m);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
Multicycle MIPS main control unit. It is the producer side of the ALUOp interface that the ALU control decoder consumes, and it sequences fetch, decode, execute, memory and writeback. It sits between the instruction register opcode field, the memory handshake, and the datapath muxes and write enables.

Parameters:
TIMEOUT_CYCLES, 255, max wait cycles for mem_ready in any memory state before trapping
TIMEOUT_W, 8, width of the wait counter; must hold TIMEOUT_CYCLES

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-low reset
opcode  in  6  instr[31:26] from IR, valid from DECODE onward
mem_ready  in  1  memory completes the current read/write this cycle
PCWrite  out  1  PC load enable
IRWrite  out  1  IR load enable
MemRead  out  1  memory read request
MemWrite  out  1  memory write request
IorD  out  1  0 = PC address, 1 = ALUOut address
RegWrite  out  1  register file write enable
RegDst  out  1  1 = rd, 0 = rt
MemtoReg  out  1  1 = MDR, 0 = ALUOut
ALUSrcA  out  1  0 = PC, 1 = rs
ALUSrcB  out  2  00 = rt, 01 = const 4, 10 = sign-ext imm, 11 = imm<<2
PCSource  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
ALUOp  out  3  111 = R-type, 110 = add, 101 = or, 001 = and, 000 = idle
illegal_op  out  1  sticky: unsupported opcode trap
mem_timeout  out  1  sticky: memory wait expired
state_o  out  4  current state code, for debug

Behaviour:
- One clock domain. Reset is synchronous and active-low: on a clk edge with reset==0, state=FETCH, the wait counter is 0, and illegal_op and mem_timeout are 0. While reset==0, every strobe output is forced to 0 and ALUOp is 000.
- Outputs decode combinationally from the registered state. PCWrite and IRWrite in FETCH are additionally gated by mem_ready.
- Unlisted outputs are 0 in each state.
- States, state_o code, and outputs:
  - FETCH (0): MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=110, PCSource=00.
    - On mem_ready: IRWrite=1, PCWrite=1, go to DECODE. Otherwise stay.
  - DECODE (1): ALUSrcA=0, ALUSrcB=11, ALUOp=110. Next state by opcode:
    - 000000 -> R_EXEC
    - 001000 / 001101 / 001100 -> I_EXEC
    - 100011 / 101011 -> MEM_ADDR
    - 000010 -> JUMP
    - any other -> ILLEGAL
  - R_EXEC (2): ALUSrcA=1, ALUSrcB=00, ALUOp=111 -> R_WB.
  - R_WB (3): RegWrite=1, RegDst=1, MemtoReg=0 -> FETCH.
  - I_EXEC (4): ALUSrcA=1, ALUSrcB=10. ALUOp is 110 for ADDI, 101 for ORI, 001 for ANDI. -> I_WB.
  - I_WB (5): RegWrite=1, RegDst=0, MemtoReg=0 -> FETCH.
  - MEM_ADDR (6): ALUSrcA=1, ALUSrcB=10, ALUOp=110. LW -> MEM_RD, SW -> MEM_WR.
  - MEM_RD (7): MemRead=1, IorD=1. On mem_ready -> MEM_WB.
  - MEM_WB (8): RegWrite=1, RegDst=0, MemtoReg=1 -> FETCH.
  - MEM_WR (9): MemWrite=1, IorD=1. On mem_ready -> FETCH.
  - JUMP (10): PCWrite=1, PCSource=10 -> FETCH.
  - ILLEGAL (15): all strobes 0. Stays here until reset.
- opcode is sampled each cycle it is needed; the IR holds it stable from DECODE until return to FETCH.
- Latency, counting mem_ready on the first cycle:
  - R-type and I-type: 4 cycles.
  - LW: 5 cycles.
  - SW: 4 cycles.
  - J: 3 cycles.
- Wait counter (FETCH, MEM_RD, MEM_WR):
  - Increments each cycle mem_ready==0; clears on state exit.
  - When the count reaches TIMEOUT_CYCLES with mem_ready still 0: set mem_timeout=1 and go to ILLEGAL.
  - mem_ready==1 in the same cycle the count hits the limit wins: normal transition, no timeout.
- illegal_op is set on the DECODE->ILLEGAL transition. mem_timeout is set on the timeout transition. Both are cleared only by reset.
- Reset asserted mid-instruction aborts it. No write strobe is asserted in the reset cycle.

Optional Feature:
Macro BRANCH_EN adds BEQ support.
- With BRANCH_EN defined:
  - opcode 000100 in DECODE -> BRANCH (state 11).
  - BRANCH drives ALUSrcA=1, ALUSrcB=00, ALUOp=011 (subtract, a new ALU control row), PCSource=01.
  - Input zero (1 bit, ALU zero flag) is added. PCWrite = zero during BRANCH. Next state is FETCH.
  - BEQ latency is 3 cycles.
- Without BRANCH_EN: the zero port does not exist, and opcode 000100 traps to ILLEGAL.

Test Plan:
1. reset=0 for 2 edges, then 1, mem_ready=0 -> state_o=0, MemRead=1, IorD=0, ALUOp=110, PCWrite=IRWrite=0, flags 0.
2. opcode 000000, mem_ready=1 in FETCH -> state_o sequence 0,1,2,3,0. R_EXEC shows ALUOp=111, ALUSrcB=00. R_WB shows RegWrite=1, RegDst=1.
3. opcodes 001000, 001101, 001100 in turn -> ALUOp in I_EXEC is 110, 101, 001. ALUSrcB=10. I_WB shows RegWrite=1, RegDst=0.
4. LW (100011) with mem_ready low for 3 cycles in MEM_RD -> MemRead=1, IorD=1 held for 4 cycles, then MEM_WB with MemtoReg=1, RegWrite=1, then FETCH.
5. opcode 111111 -> state_o=15, illegal_op=1 held for 20 cycles. reset=0 for one edge -> state_o=0, illegal_op=0.
6. TIMEOUT_CYCLES=4, mem_ready stuck 0 in FETCH -> after 4 wait cycles state_o=15, mem_timeout=1, illegal_op=0. Repeat with mem_ready=1 on the 4th cycle -> DECODE, no timeout.
